// File: rtl/vdp_io_pkg.sv
// Shared types for the VDP CPU I/O queue: FSM state encoding, queued
// request record and the VDP port offsets seen on io_port / vdp_adr.
package vdp_io_pkg;

  typedef enum logic [1:0] {
    IO_IDLE    = 2'd0,
    IO_WR_REQ  = 2'd1,
    IO_RD_WAIT = 2'd2,
    IO_RD_REQ  = 2'd3
  } io_state_t;

  typedef struct packed {
    logic [1:0] port;
    logic [7:0] data;
  } io_req_t;

  localparam logic [1:0] VDP_PORT_DATA = 2'd0;
  localparam logic [1:0] VDP_PORT_CTRL = 2'd1;
  localparam logic [1:0] VDP_PORT_PAL  = 2'd2;
  localparam logic [1:0] VDP_PORT_IREG = 2'd3;

endpackage

// File: rtl/vdp_io_fifo.sv
// Synchronous FIFO of io_req_t. The head is visible on dout whenever the
// FIFO is not empty; pointers carry one extra bit so full/empty never alias.
module vdp_io_fifo
  import vdp_io_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  io_req_t       din,
  input  logic          pop,
  output io_req_t       dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  io_req_t     mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // pointer update; overflowing pushes and underflowing pops are ignored
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // storage write, no reset needed: only entries between the pointers are read
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/vdp_cpu_io_queue.sv
// Posted-write queue and ordered-read sequencer in front of the VDP core.
// Optional build macro: VDP_IO_QUEUE_STATS_EN adds saturating counters for
// accepted writes (stat_writes) and overflow drops (stat_drops).
//
// state      | meaning
// IO_IDLE    | no request on the VDP port, no read pending
// IO_WR_REQ  | FIFO head presented to the VDP as a write
// IO_RD_WAIT | read pending, older writes still draining
// IO_RD_REQ  | read presented to the VDP
//
// A write stays in the FIFO until it retires (ack or timeout), so the FIFO
// count always includes an in-flight write; that keeps rd_ahead exact.
module vdp_cpu_io_queue
  import vdp_io_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int ACK_TIMEOUT = 31
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        io_wr_stb,
  input  logic        io_rd_stb,
  input  logic [1:0]  io_port,
  input  logic [7:0]  io_wdata,
  output logic [7:0]  io_rdata,
  output logic        io_rd_valid,
  output logic        io_busy,
  output logic        io_full,
  output logic        vdp_req,
  output logic        vdp_wrt,
  output logic [1:0]  vdp_adr,
  output logic [7:0]  vdp_dbo,
  input  logic        vdp_ack,
  input  logic [7:0]  vdp_dbi,
  output logic        err_timeout,
  output logic        err_overflow
`ifdef VDP_IO_QUEUE_STATS_EN
  ,
  output logic [15:0] stat_writes,
  output logic [7:0]  stat_drops
`endif
);

  localparam int          AW       = $clog2(DEPTH);
  localparam int          TW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW:0] DEPTH_C  = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TMR_LOAD = TW'(ACK_TIMEOUT - 1);

  io_state_t     state;
  logic [TW-1:0] tmr;
  logic [AW:0]   rd_ahead;
  logic [1:0]    rd_port;

  io_req_t       in_req;
  io_req_t       fifo_dout;
  io_req_t       wr_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_count;
  logic          fifo_push;
  logic          retire_wr;
  logic          rd_new;
  logic          rd_go;
  logic          wr_avail;
  logic [AW+1:0] rd_sum;
  logic [AW:0]   rd_load_val;

  assign in_req.port = io_port;
  assign in_req.data = io_wdata;

  assign fifo_push = io_wr_stb && !fifo_full;
  assign retire_wr = (state == IO_WR_REQ) && (vdp_ack || (tmr == '0));
  assign rd_new    = io_rd_stb && !io_busy;

  // writes older than a new read: everything queued, plus a same-cycle push,
  // minus a write retiring this very cycle
  assign rd_sum      = {1'b0, fifo_count} + {{(AW + 1){1'b0}}, fifo_push}
                       - {{(AW + 1){1'b0}}, retire_wr};
  assign rd_load_val = (rd_sum > {1'b0, DEPTH_C}) ? DEPTH_C : rd_sum[AW:0];

  assign rd_go    = io_busy ? (rd_ahead == '0) : (rd_new && (rd_load_val == '0));
  assign wr_avail = !fifo_empty || fifo_push;
  // an empty FIFO forwards the incoming write so it reaches the VDP next cycle
  assign wr_head  = fifo_empty ? in_req : fifo_dout;
  assign io_full  = fifo_full;

  vdp_io_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (in_req),
    .pop     (retire_wr),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // count of older writes still ahead of the pending read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ahead <= '0;
      rd_port  <= '0;
    end else if (rd_new) begin
      rd_ahead <= rd_load_val;
      rd_port  <= io_port;
    end else if (retire_wr && (rd_ahead != '0)) begin
      rd_ahead <= rd_ahead - 1'b1;
    end
  end

  // request sequencer with registered VDP-side and CPU-side outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IO_IDLE;
      tmr          <= '0;
      vdp_req      <= 1'b0;
      vdp_wrt      <= 1'b0;
      vdp_adr      <= '0;
      vdp_dbo      <= '0;
      io_rdata     <= '0;
      io_rd_valid  <= 1'b0;
      io_busy      <= 1'b0;
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      io_rd_valid <= 1'b0;
      if (rd_new) io_busy <= 1'b1;
      if (io_wr_stb && fifo_full) err_overflow <= 1'b1;

      unique case (state)
        IO_IDLE, IO_RD_WAIT: begin
          if (rd_go) begin
            state   <= IO_RD_REQ;
            vdp_req <= 1'b1;
            vdp_wrt <= 1'b0;
            vdp_adr <= io_busy ? rd_port : io_port;
            vdp_dbo <= '0;
            tmr     <= TMR_LOAD;
          end else if (wr_avail) begin
            state   <= IO_WR_REQ;
            vdp_req <= 1'b1;
            vdp_wrt <= 1'b1;
            vdp_adr <= wr_head.port;
            vdp_dbo <= wr_head.data;
            tmr     <= TMR_LOAD;
          end else begin
            state <= (io_busy || rd_new) ? IO_RD_WAIT : IO_IDLE;
          end
        end

        IO_WR_REQ: begin
          if (retire_wr) begin
            vdp_req <= 1'b0;
            vdp_wrt <= 1'b0;
            state   <= (io_busy || rd_new) ? IO_RD_WAIT : IO_IDLE;
            if (!vdp_ack) err_timeout <= 1'b1;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        IO_RD_REQ: begin
          if (vdp_ack || (tmr == '0)) begin
            vdp_req     <= 1'b0;
            io_rdata    <= vdp_ack ? vdp_dbi : 8'hFF;
            io_rd_valid <= 1'b1;
            io_busy     <= 1'b0;
            state       <= IO_IDLE;
            if (!vdp_ack) err_timeout <= 1'b1;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        default: state <= IO_IDLE;
      endcase
    end
  end

`ifdef VDP_IO_QUEUE_STATS_EN
  // saturating traffic statistics
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_writes <= '0;
      stat_drops  <= '0;
    end else begin
      if (fifo_push && (stat_writes != 16'hFFFF)) stat_writes <= stat_writes + 1'b1;
      if (io_wr_stb && fifo_full && (stat_drops != 8'hFF)) stat_drops <= stat_drops + 1'b1;
    end
  end
`endif

endmodule
